// File: rtl/msi_irq_ctrl.sv
// Multi-source interrupt-to-MSI controller. It catches rising edges on the
// irq_in lines as pending bits and picks among them round-robin. It issues one
// cfg_interrupt request at a time, and re-arms level sources that are still
// high once their holdoff timer runs out.
module msi_irq_ctrl #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned VECTOR_BASE    = 1,
  parameter int unsigned HOLDOFF_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               msi_enable,
  input  logic [2:0]         msi_mmenable,
  output logic               cfg_interrupt,
  input  logic               cfg_interrupt_rdy,
  output logic [7:0]         cfg_interrupt_di,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic [15:0]        msi_sent_cnt
);

  localparam int unsigned IdxW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned TimerW = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  irq_q;
  logic [NUM_SRC-1:0]  pend_q, pend_d;
  logic [NUM_SRC-1:0]  rise, expire, eligible, grant_vec;
  logic [TimerW-1:0]   timer_q [NUM_SRC];
  logic [TimerW-1:0]   timer_d [NUM_SRC];
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     win_q, win_d;
  logic [IdxW-1:0]     sel_idx;
  logic                sel_found;
  logic                cfg_int_q, cfg_int_d;
  logic [7:0]          di_q, di_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                grant;
  logic [7:0]          fold_mask;
  logic [7:0]          vec_fold;

  assign rise     = irq_in & ~irq_q;
  assign eligible = pend_q & ~irq_mask;

  // Round-robin search starting at the source after the last one granted.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = (32'(rr_q) + i) % NUM_SRC;
      if (!sel_found && eligible[IdxW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(idx);
      end
    end
  end

  // Fold the winner's vector to the host-allocated count (at most 32 vectors).
  always_comb begin
    unique case (msi_mmenable)
      3'd0:    fold_mask = 8'h00;
      3'd1:    fold_mask = 8'h01;
      3'd2:    fold_mask = 8'h03;
      3'd3:    fold_mask = 8'h07;
      3'd4:    fold_mask = 8'h0f;
      default: fold_mask = 8'h1f;
    endcase
    vec_fold = (8'(VECTOR_BASE) + 8'(sel_idx)) & fold_mask;
  end

  // Request FSM: next state, registered request outputs and grant bookkeeping.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rr_d      = rr_q;
    cfg_int_d = 1'b0;
    di_d      = di_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (msi_enable && sel_found) begin
          state_d   = StReq;
          win_d     = sel_idx;
          cfg_int_d = 1'b1;
          di_d      = vec_fold;
        end
      end
      StReq: begin
        cfg_int_d = 1'b1;
        if (cfg_interrupt_rdy) begin
          grant     = 1'b1;
          cfg_int_d = 1'b0;
          cnt_d     = cnt_q + 16'd1;
          rr_d      = (win_q == IdxW'(NUM_SRC - 1)) ? '0 : win_q + IdxW'(1);
          state_d   = StGap;
        end else if (!msi_enable) begin
          // Host withdrew MSI: drop the request, pending bit stays set.
          cfg_int_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-source pending bits and holdoff timers; a new set beats a grant clear.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      grant_vec[i] = grant && (win_q == IdxW'(i));
      expire[i]    = (HOLDOFF_CYCLES != 0) && (timer_q[i] == TimerW'(1)) && irq_in[i];
      if (grant_vec[i]) begin
        timer_d[i] = TimerW'(HOLDOFF_CYCLES);
      end else if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - TimerW'(1);
      end else begin
        timer_d[i] = timer_q[i];
      end
    end
    pend_d = (pend_q & ~grant_vec) | rise | expire;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      irq_q     <= '0;
      pend_q    <= '0;
      rr_q      <= '0;
      win_q     <= '0;
      cfg_int_q <= 1'b0;
      di_q      <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) timer_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_in;
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      cfg_int_q <= cfg_int_d;
      di_q      <= di_d;
      cnt_q     <= cnt_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) timer_q[i] <= timer_d[i];
    end
  end

  assign cfg_interrupt    = cfg_int_q;
  assign cfg_interrupt_di = di_q;
  assign irq_pending      = pend_q;
  assign msi_sent_cnt     = cnt_q;

endmodule

// File: tb/tb_msi_irq_ctrl.sv
// Directed bench for msi_irq_ctrl: basic request, round-robin order, vector
// folding, holdoff re-arm, enable/abort, masking and asynchronous reset.
module tb_msi_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       msi_enable;
  logic [2:0] msi_mmenable;
  logic       cfg_interrupt;
  logic       cfg_interrupt_rdy;
  logic [7:0] cfg_interrupt_di;
  logic [3:0] irq_pending;
  logic [15:0] msi_sent_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int seen;

  msi_irq_ctrl #(
    .NUM_SRC        (4),
    .VECTOR_BASE    (1),
    .HOLDOFF_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .irq_in            (irq_in),
    .irq_mask          (irq_mask),
    .msi_enable        (msi_enable),
    .msi_mmenable      (msi_mmenable),
    .cfg_interrupt     (cfg_interrupt),
    .cfg_interrupt_rdy (cfg_interrupt_rdy),
    .cfg_interrupt_di  (cfg_interrupt_di),
    .irq_pending       (irq_pending),
    .msi_sent_cnt      (msi_sent_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n             = 1'b0;
    irq_in            = 4'b0000;
    irq_mask          = 4'b0000;
    msi_enable        = 1'b1;
    msi_mmenable      = 3'd2;
    cfg_interrupt_rdy = 1'b0;
    #3;
    chk("rst_cfg_int", 32'(cfg_interrupt), 32'h0);
    chk("rst_di", 32'(cfg_interrupt_di), 32'h0);
    chk("rst_pend", 32'(irq_pending), 32'h0);
    chk("rst_cnt", 32'(msi_sent_cnt), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic: one-cycle pulse on source 0, grant three cycles into the request.
    irq_in = 4'b0001;
    tick();
    chk("basic_pend_set", 32'(irq_pending), 32'h1);
    chk("basic_no_req_yet", 32'(cfg_interrupt), 32'h0);
    irq_in = 4'b0000;
    tick();
    chk("basic_req", 32'(cfg_interrupt), 32'h1);
    chk("basic_di", 32'(cfg_interrupt_di), 32'h01);
    tick();
    tick();
    chk("basic_req_held", 32'(cfg_interrupt), 32'h1);
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    chk("basic_req_drop", 32'(cfg_interrupt), 32'h0);
    chk("basic_cnt", 32'(msi_sent_cnt), 32'h1);
    chk("basic_pend_clr", 32'(irq_pending), 32'h0);
    tick();
    tick();

    // Round-robin with eight vectors so source 3 keeps vector 4.
    msi_mmenable = 3'd3;
    irq_in = 4'b0110;
    tick();
    chk("rr_pend", 32'(irq_pending), 32'h6);
    irq_in = 4'b0000;
    tick();
    chk("rr_req1", 32'(cfg_interrupt), 32'h1);
    chk("rr_di1", 32'(cfg_interrupt_di), 32'h02);
    cfg_interrupt_rdy = 1'b1;  // held high through GAP/IDLE, where it is ignored
    tick();
    chk("rr_pend_after1", 32'(irq_pending), 32'h4);
    tick();
    chk("rr_gap_idle", 32'(cfg_interrupt), 32'h0);
    tick();
    chk("rr_req2", 32'(cfg_interrupt), 32'h1);
    chk("rr_di2", 32'(cfg_interrupt_di), 32'h03);
    tick();
    cfg_interrupt_rdy = 1'b0;
    chk("rr_cnt2", 32'(msi_sent_cnt), 32'h3);
    chk("rr_pend_empty", 32'(irq_pending), 32'h0);
    tick();
    tick();
    irq_in = 4'b1010;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("rr_di_src3_first", 32'(cfg_interrupt_di), 32'h04);
    cfg_interrupt_rdy = 1'b1;
    tick();
    tick();
    tick();
    chk("rr_req_src1", 32'(cfg_interrupt), 32'h1);
    chk("rr_di_src1", 32'(cfg_interrupt_di), 32'h02);
    tick();
    cfg_interrupt_rdy = 1'b0;
    chk("rr_cnt4", 32'(msi_sent_cnt), 32'h5);
    tick();
    tick();

    // Folding to one vector, then to two.
    msi_mmenable = 3'd0;
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("fold0_di", 32'(cfg_interrupt_di), 32'h00);
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    tick();
    tick();
    msi_mmenable = 3'd1;
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("fold1_di", 32'(cfg_interrupt_di), 32'h01);
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    chk("fold_cnt", 32'(msi_sent_cnt), 32'h7);
    tick();
    tick();
    msi_mmenable = 3'd2;

    // Re-arm: source 0 held high, grant at edge m, re-request after m+17.
    irq_in = 4'b0001;
    tick();
    tick();
    chk("rearm_req1", 32'(cfg_interrupt), 32'h1);
    cfg_interrupt_rdy = 1'b1;
    tick();  // edge m
    cfg_interrupt_rdy = 1'b0;
    chk("rearm_cnt1", 32'(msi_sent_cnt), 32'h8);
    for (int i = 1; i <= 15; i++) tick();
    chk("rearm_pend_m15", 32'(irq_pending), 32'h0);
    tick();  // m+16
    chk("rearm_pend_m16", 32'(irq_pending), 32'h1);
    chk("rearm_noreq_m16", 32'(cfg_interrupt), 32'h0);
    tick();  // m+17
    chk("rearm_req_m17", 32'(cfg_interrupt), 32'h1);
    chk("rearm_di", 32'(cfg_interrupt_di), 32'h01);
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    tick();
    irq_in = 4'b0000;  // dropped well before the next expiry
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (cfg_interrupt) seen++;
    end
    chk("rearm_dropped_noreq", 32'(seen), 32'h0);
    chk("rearm_cnt2", 32'(msi_sent_cnt), 32'h9);

    // Enable gating and abort of an in-flight request.
    msi_enable = 1'b0;
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    chk("en_pend_held", 32'(irq_pending), 32'h2);
    chk("en_noreq", 32'(cfg_interrupt), 32'h0);
    msi_enable = 1'b1;
    tick();
    chk("en_req", 32'(cfg_interrupt), 32'h1);
    chk("en_di", 32'(cfg_interrupt_di), 32'h02);
    msi_enable = 1'b0;
    tick();
    chk("abort_req_drop", 32'(cfg_interrupt), 32'h0);
    chk("abort_pend_kept", 32'(irq_pending), 32'h2);
    chk("abort_cnt_same", 32'(msi_sent_cnt), 32'h9);
    msi_enable = 1'b1;
    tick();
    chk("reen_req", 32'(cfg_interrupt), 32'h1);
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    chk("reen_cnt", 32'(msi_sent_cnt), 32'ha);
    tick();
    tick();

    // Masking keeps the pending bit but blocks arbitration.
    irq_mask = 4'b0001;
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    chk("mask_pend", 32'(irq_pending), 32'h1);
    chk("mask_noreq", 32'(cfg_interrupt), 32'h0);
    irq_mask = 4'b0000;
    tick();
    chk("unmask_req", 32'(cfg_interrupt), 32'h1);

    // Asynchronous reset in the middle of a request.
    #2;
    rst_n = 1'b0;
    irq_in = 4'b0001;
    #1;
    chk("arst_cfg_int", 32'(cfg_interrupt), 32'h0);
    chk("arst_di", 32'(cfg_interrupt_di), 32'h0);
    chk("arst_pend", 32'(irq_pending), 32'h0);
    chk("arst_cnt", 32'(msi_sent_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_pend", 32'(irq_pending), 32'h1);
    tick();
    chk("post_rst_req", 32'(cfg_interrupt), 32'h1);
    chk("post_rst_di", 32'(cfg_interrupt_di), 32'h01);
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    tick();
    irq_in = 4'b0000;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (cfg_interrupt) seen++;
    end
    chk("post_rst_single", 32'(seen), 32'h0);
    chk("post_rst_cnt", 32'(msi_sent_cnt), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
